// File: rtl/m_serial_adder.sv
// Bit-serial ripple adder: one m_FA plus a carry flop, processing one bit pair
// per clock LSB first and publishing {cout, sum} once all WIDTH bits are done.

module m_FA (
  input  logic w_a,
  input  logic w_b,
  input  logic w_cin,
  output logic w_s,
  output logic w_cout
);
  assign w_s    = w_a ^ w_b ^ w_cin;
  assign w_cout = (w_a & w_b) | (w_cin & (w_a ^ w_b));
endmodule

module m_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             w_clk,
  input  logic             w_rst_n,
  input  logic             w_start,
  input  logic [WIDTH-1:0] w_a,
  input  logic [WIDTH-1:0] w_b,
  input  logic             w_cin,
  output logic             w_busy,
  output logic             w_done,
  output logic [WIDTH-1:0] w_sum,
  output logic             w_cout
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a_sr, r_b_sr, r_sum_sr;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic             w_fa_s, w_fa_cout;
  logic             w_last, w_accept;
  logic [WIDTH-1:0] w_s_msb, w_sum_nxt;

  m_FA u_fa (
    .w_a    (r_a_sr[0]),
    .w_b    (r_b_sr[0]),
    .w_cin  (r_carry),
    .w_s    (w_fa_s),
    .w_cout (w_fa_cout)
  );

  assign w_last   = (r_cnt == CW'(WIDTH - 1));
  // A start is honoured in IDLE and DONE only; RUN ignores it entirely.
  assign w_accept = w_start && (r_state != S_RUN);

  always_comb begin
    w_s_msb            = '0;
    w_s_msb[WIDTH-1]   = w_fa_s;
    w_sum_nxt          = (r_sum_sr >> 1) | w_s_msb;
  end

  always_ff @(posedge w_clk) begin
    if (!w_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last)  w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = w_start ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_sum_sr <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
    end else if (w_accept) begin
      r_a_sr   <= w_a;
      r_b_sr   <= w_b;
      r_sum_sr <= '0;
      r_carry  <= w_cin;
      r_cnt    <= '0;
    end else if (r_state == S_RUN) begin
      r_a_sr   <= r_a_sr >> 1;
      r_b_sr   <= r_b_sr >> 1;
      r_sum_sr <= w_sum_nxt;
      r_carry  <= w_fa_cout;
      r_cnt    <= r_cnt + 1'b1;
      // Results are published only on the final bit, so partial sums never leak.
      if (w_last) begin
        r_sum  <= w_sum_nxt;
        r_cout <= w_fa_cout;
      end
    end
  end

  assign w_busy = (r_state == S_RUN);
  assign w_done = (r_state == S_DONE);
  assign w_sum  = r_sum;
  assign w_cout = r_cout;
endmodule

// File: tb/tb_m_serial_adder.sv
// Directed bench for m_serial_adder (WIDTH=8): reset, arithmetic, ignored
// starts, back-to-back issue and mid-operation reset.

module tb_m_serial_adder;
  localparam int WIDTH = 8;

  logic             w_clk = 1'b0;
  logic             w_rst_n = 1'b0;
  logic             w_start = 1'b0;
  logic [WIDTH-1:0] w_a = '0;
  logic [WIDTH-1:0] w_b = '0;
  logic             w_cin = 1'b0;
  logic             w_busy, w_done, w_cout;
  logic [WIDTH-1:0] w_sum;

  int vectors = 0;
  int miscompares = 0;

  m_serial_adder #(.WIDTH(WIDTH)) dut (
    .w_clk   (w_clk),
    .w_rst_n (w_rst_n),
    .w_start (w_start),
    .w_a     (w_a),
    .w_b     (w_b),
    .w_cin   (w_cin),
    .w_busy  (w_busy),
    .w_done  (w_done),
    .w_sum   (w_sum),
    .w_cout  (w_cout)
  );

  always #5 w_clk = ~w_clk;

  // Advance one rising edge and settle just past it.
  task automatic tick();
    @(posedge w_clk);
    #1;
  endtask

  // Issue a start, then wait for done; checks busy length, result and pulse width.
  task automatic do_op(input string name, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input logic [7:0] esum, input logic ecout);
    int busy_cnt = 0;
    bit seen = 0;
    w_a = a; w_b = b; w_cin = cin; w_start = 1'b1;
    tick();
    w_start = 1'b0; w_a = 8'hA5; w_b = 8'hC3; w_cin = ~cin;
    for (int i = 0; i < 20; i++) begin
      if (w_busy) busy_cnt++;
      if (w_done) begin seen = 1; break; end
      tick();
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL %s done_timeout: no w_done within 20 cycles", name);
    end
    vectors++;
    if (busy_cnt !== WIDTH) begin
      miscompares++;
      $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_cnt, WIDTH);
    end
    vectors++;
    if (w_sum !== esum || w_cout !== ecout) begin
      miscompares++;
      $display("FAIL %s result: got cout=%0b sum=%02h want cout=%0b sum=%02h",
               name, w_cout, w_sum, ecout, esum);
    end
    tick();
    vectors++;
    if (w_done !== 1'b0 || w_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s post_done: got done=%0b busy=%0b want 0/0", name, w_done, w_busy);
    end
  endtask

  task automatic test_reset();
    w_rst_n = 1'b0;
    tick(); tick();
    vectors++;
    if (w_sum !== 8'h00 || w_cout !== 1'b0 || w_busy !== 1'b0 || w_done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: got sum=%02h cout=%0b busy=%0b done=%0b want all 0",
               w_sum, w_cout, w_busy, w_done);
    end
    w_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (w_busy !== 1'b0 || w_done !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_hold: cycle %0d got busy=%0b done=%0b want 0/0", i, w_busy, w_done);
      end
    end
  endtask

  task automatic test_basic();
    do_op("basic", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
  endtask

  task automatic test_carry();
    do_op("carry_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    do_op("carry_ff_ff_1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    do_op("carry_cin_only", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0);
  endtask

  task automatic test_start_busy();
    int dones = 0;
    w_a = 8'h5A; w_b = 8'h3C; w_cin = 1'b0; w_start = 1'b1;
    tick();
    w_start = 1'b0;
    tick(); tick(); tick();
    w_a = 8'h11; w_b = 8'h22; w_start = 1'b1;
    tick();
    w_start = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (w_done) begin
        dones++;
        vectors++;
        if (w_sum !== 8'h96 || w_cout !== 1'b0) begin
          miscompares++;
          $display("FAIL busy_start_result: got cout=%0b sum=%02h want 0/96", w_cout, w_sum);
        end
      end
      tick();
    end
    vectors++;
    if (dones !== 1) begin
      miscompares++;
      $display("FAIL busy_start_pulses: got %0d want 1", dones);
    end
    vectors++;
    if (w_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_start_idle: got busy=%0b want 0", w_busy);
    end
  endtask

  task automatic test_back_to_back();
    int gap = 0;
    bit seen = 0;
    bit held = 1;
    w_a = 8'h5A; w_b = 8'h3C; w_cin = 1'b0; w_start = 1'b1;
    tick();
    w_start = 1'b0;
    for (int i = 0; i < 20 && !w_done; i++) tick();
    vectors++;
    if (w_done !== 1'b1 || w_sum !== 8'h96) begin
      miscompares++;
      $display("FAIL b2b_first: got done=%0b sum=%02h want 1/96", w_done, w_sum);
    end
    w_a = 8'h80; w_b = 8'h80; w_cin = 1'b0; w_start = 1'b1;
    tick();
    w_start = 1'b0;
    gap = 1;
    vectors++;
    if (w_busy !== 1'b1 || w_done !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_accept: got busy=%0b done=%0b want 1/0", w_busy, w_done);
    end
    for (int i = 0; i < 20; i++) begin
      if (w_done) begin seen = 1; break; end
      if (w_sum !== 8'h96) held = 0;
      tick();
      gap++;
    end
    vectors++;
    if (!seen || gap !== 9) begin
      miscompares++;
      $display("FAIL b2b_gap: got seen=%0b gap=%0d want 1/9", seen, gap);
    end
    vectors++;
    if (!held) begin
      miscompares++;
      $display("FAIL b2b_hold: w_sum changed before second done, want 96 held");
    end
    vectors++;
    if (w_sum !== 8'h00 || w_cout !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_result: got cout=%0b sum=%02h want 1/00", w_cout, w_sum);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    w_a = 8'h5A; w_b = 8'h3C; w_cin = 1'b0; w_start = 1'b1;
    tick();
    w_start = 1'b0;
    tick(); tick(); tick();
    w_rst_n = 1'b0;
    tick();
    vectors++;
    if (w_sum !== 8'h00 || w_cout !== 1'b0 || w_busy !== 1'b0 || w_done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: got sum=%02h cout=%0b busy=%0b done=%0b want all 0",
               w_sum, w_cout, w_busy, w_done);
    end
    w_rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (w_done) dones++;
      tick();
    end
    vectors++;
    if (dones !== 0) begin
      miscompares++;
      $display("FAIL reset_mid_nodone: got %0d done pulses want 0", dones);
    end
    do_op("after_reset", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_start_busy();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
